// File: rtl/vdp_super_vram_slot_arbiter.sv
// Super-res VRAM slot arbiter.
// Time is cut into 4-clock access groups aligned to cx[1:0]. One clock before a
// group starts (phase 3) a single owner is chosen for it: display fetch, the CPU
// or command port (round robin), SDRAM refresh, or nobody. The chosen access is
// presented to the SDRAM controller unchanged for the whole group.
module vdp_super_vram_slot_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int REF_MAX    = 7,
    parameter int REF_URGENT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [9:0]        cx,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wmask,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              cmd_req,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wmask,
    output logic              cmd_ack,
    output logic [31:0]       cmd_rdata,
    input  logic              refresh_req,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [31:0]       vram_wdata,
    output logic [3:0]        vram_wmask,
    output logic              vram_refresh,
    input  logic [31:0]       vram_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_REQ  = 2'd2;
    localparam logic [1:0] OWN_REF  = 2'd3;

    localparam logic [2:0] REF_MAX_C    = 3'(REF_MAX);
    localparam logic [2:0] REF_URGENT_C = 3'(REF_URGENT);

    // Only the group phase matters; the column number itself is irrelevant here.
    logic [1:0] phase;
    logic       unused_cx;
    assign phase     = cx[1:0];
    assign unused_cx = ^cx[9:2];

    logic       decide;
    assign decide = (phase == 2'd3);

    logic [2:0] ref_pending;   // refresh requests not yet served
    logic       rr_cmd;        // round-robin preference: 0 = CPU next, 1 = command next
    logic       sel_cmd;       // requester group belongs to the command port
    logic [1:0] next_owner;
    logic       next_cmd;
    logic       want_cpu;
    logic       want_cmd;
    logic       ref_dec;

    assign want_cpu = enable & cpu_req;
    assign want_cmd = enable & cmd_req;
    assign ref_dec  = decide && (next_owner == OWN_REF);

    // Owner selection for the next group in fixed priority order.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        next_owner = OWN_IDLE;
        next_cmd   = 1'b0;
        if (enable && disp_req) begin
            next_owner = OWN_DISP;
        end else if (ref_pending >= REF_URGENT_C) begin
            next_owner = OWN_REF;
        end else if (want_cpu || want_cmd) begin
            next_owner = OWN_REQ;
            next_cmd   = want_cmd & (~want_cpu | rr_cmd);
        end else if (ref_pending != 3'd0) begin
            next_owner = OWN_REF;
        end
    end

    // Register the winner and its access at the decision edge; hold for the group.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
        if (!reset_n) begin
            owner        <= OWN_IDLE;
            sel_cmd      <= 1'b0;
            rr_cmd       <= 1'b0;
            vram_addr    <= '0;
            vram_we      <= 1'b0;
            vram_wdata   <= '0;
            vram_wmask   <= '0;
            vram_refresh <= 1'b0;
        end else if (decide) begin
            owner        <= next_owner;
            sel_cmd      <= next_cmd;
            vram_we      <= 1'b0;
            vram_refresh <= 1'b0;
            case (next_owner)
                OWN_DISP: vram_addr <= disp_addr;
                OWN_REQ: begin
                    rr_cmd <= ~next_cmd;
                    if (next_cmd) begin
                        vram_addr  <= cmd_addr;
                        vram_we    <= cmd_we;
                        vram_wdata <= cmd_wdata;
                        vram_wmask <= cmd_wmask;
                    end else begin
                        vram_addr  <= cpu_addr;
                        vram_we    <= cpu_we;
                        vram_wdata <= cpu_wdata;
                        vram_wmask <= cpu_wmask;
                    end
                end
                OWN_REF: vram_refresh <= 1'b1;
                default: ;
            endcase
        end
    end

    // Pending-refresh counter: pulses add, refresh grants subtract, both at once cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_pending <= 3'd0;
        end else if (ref_dec && !refresh_req) begin
            ref_pending <= ref_pending - 3'd1;
        end else if (!ref_dec && refresh_req && (ref_pending != REF_MAX_C)) begin
            ref_pending <= ref_pending + 3'd1;
        end
    end

    // Requester completion: capture read data at the phase-1 edge, ack during phase 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack   <= 1'b0;
            cmd_ack   <= 1'b0;
            cpu_rdata <= '0;
            cmd_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cmd_ack <= 1'b0;
            if (phase == 2'd1 && owner == OWN_REQ) begin
                if (sel_cmd) begin
                    cmd_ack <= 1'b1;
                    if (!vram_we) cmd_rdata <= vram_rdata;
                end else begin
                    cpu_ack <= 1'b1;
                    if (!vram_we) cpu_rdata <= vram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp_super_vram_slot_arbiter.sv
// Self-checking bench for vdp_super_vram_slot_arbiter.
// A table of per-group stimulus records drives the arbitration scenarios; the
// CPU write group and the mid-group reset are hand-written sequences.
module tb_vdp_super_vram_slot_arbiter;

    localparam int ADDR_W = 18;
    localparam logic [17:0] CPU_A  = 18'h11111;
    localparam logic [17:0] CMD_A  = 18'h22222;
    localparam logic [17:0] DISP_A = 18'h33333;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [9:0]        cx = '0;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = DISP_A;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = CPU_A;
    logic [31:0]       cpu_wdata = 32'h0;
    logic [3:0]        cpu_wmask = 4'h0;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              cmd_req = 1'b0;
    logic              cmd_we = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = CMD_A;
    logic [31:0]       cmd_wdata = 32'hCCCC_0000;
    logic [3:0]        cmd_wmask = 4'hF;
    logic              cmd_ack;
    logic [31:0]       cmd_rdata;
    logic              refresh_req = 1'b0;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [31:0]       vram_wdata;
    logic [3:0]        vram_wmask;
    logic              vram_refresh;
    logic [31:0]       vram_rdata = 32'h0;
    logic [1:0]        owner;

    vdp_super_vram_slot_arbiter #(.ADDR_W(ADDR_W), .REF_MAX(7), .REF_URGENT(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cx(cx),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wmask(cmd_wmask), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
        .refresh_req(refresh_req),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_wmask(vram_wmask), .vram_refresh(vram_refresh), .vram_rdata(vram_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_cpu_rdata = 32'h0;
    logic [31:0] exp_cmd_rdata = 32'h0;

    // One record per access group: inputs held for the group, the owner decided
    // at its end, and the acks expected in its own phase 2.
    typedef struct {
        string       name;
        bit          en;
        bit          disp;
        bit          cpu;
        bit          cmd;
        int          pulses;     // refresh pulses in phases 0..pulses-1
        logic [1:0]  exp_owner;
        logic [17:0] exp_addr;
        bit          ack_cpu;
        bit          ack_cmd;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(string n, bit en, bit disp, bit cpu, bit cmd, int pulses,
                                logic [1:0] own, logic [17:0] addr, bit acpu, bit acmd);
        vec_t v;
        v.name = n; v.en = en; v.disp = disp; v.cpu = cpu; v.cmd = cmd; v.pulses = pulses;
        v.exp_owner = own; v.exp_addr = addr; v.ack_cpu = acpu; v.ack_cmd = acmd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cx = cx + 10'd1;
    endtask

    task automatic run_group(input vec_t v, input int g);
        enable   = v.en;
        disp_req = v.disp;
        cpu_req  = v.cpu;
        cmd_req  = v.cmd;
        for (int p = 0; p < 4; p++) begin
            vram_rdata  = {16'hC0DE, 8'(g), 8'(p)};
            refresh_req = (p < v.pulses);
            if (p == 2) begin
                if (v.ack_cpu) exp_cpu_rdata = {16'hC0DE, 8'(g), 8'h01};
                if (v.ack_cmd) exp_cmd_rdata = {16'hC0DE, 8'(g), 8'h01};
                check({v.name, " cpu_ack"}, 64'(cpu_ack), 64'(v.ack_cpu));
                check({v.name, " cmd_ack"}, 64'(cmd_ack), 64'(v.ack_cmd));
                check({v.name, " cpu_rdata"}, 64'(cpu_rdata), 64'(exp_cpu_rdata));
                check({v.name, " cmd_rdata"}, 64'(cmd_rdata), 64'(exp_cmd_rdata));
            end
            if (p == 3) begin
                check({v.name, " cpu_ack_p3"}, 64'(cpu_ack), 64'd0);
                check({v.name, " cmd_ack_p3"}, 64'(cmd_ack), 64'd0);
            end
            step();
        end
        refresh_req = 1'b0;
        check({v.name, " owner"}, 64'(owner), 64'(v.exp_owner));
        check({v.name, " vram_addr"}, 64'(vram_addr), 64'(v.exp_addr));
        check({v.name, " vram_we"}, 64'(vram_we), 64'd0);
        check({v.name, " vram_refresh"}, 64'(vram_refresh), 64'(v.exp_owner == 2'd3));
    endtask

    initial begin
        bit ack_seen;

        //            name     en dsp cpu cmd pls own   addr    acpu acmd
        vecs[0]  = mk("g0",    1, 0,  0,  0,  0,  2'd0, 18'h0,  0, 0);
        vecs[1]  = mk("g1",    1, 1,  1,  0,  0,  2'd1, DISP_A, 0, 0);
        vecs[2]  = mk("g2",    1, 0,  1,  0,  0,  2'd2, CPU_A,  0, 0);
        vecs[3]  = mk("g3",    1, 1,  1,  0,  0,  2'd1, DISP_A, 1, 0);
        vecs[4]  = mk("g4",    1, 0,  1,  0,  0,  2'd2, CPU_A,  0, 0);
        vecs[5]  = mk("g5",    1, 0,  1,  1,  0,  2'd2, CMD_A,  1, 0);
        vecs[6]  = mk("g6",    1, 0,  1,  1,  0,  2'd2, CPU_A,  0, 1);
        vecs[7]  = mk("g7",    1, 0,  1,  1,  0,  2'd2, CMD_A,  1, 0);
        vecs[8]  = mk("g8",    1, 0,  0,  0,  0,  2'd0, CMD_A,  0, 1);
        vecs[9]  = mk("g9",    1, 0,  0,  0,  0,  2'd0, CMD_A,  0, 0);
        vecs[10] = mk("ref10", 1, 0,  1,  0,  2,  2'd2, CPU_A,  0, 0);
        vecs[11] = mk("ref11", 1, 0,  1,  0,  3,  2'd3, CPU_A,  1, 0);
        vecs[12] = mk("ref12", 1, 0,  1,  0,  0,  2'd3, CPU_A,  0, 0);
        vecs[13] = mk("ref13", 1, 0,  1,  0,  0,  2'd2, CPU_A,  0, 0);
        vecs[14] = mk("ref14", 1, 0,  0,  0,  0,  2'd3, CPU_A,  1, 0);
        vecs[15] = mk("ref15", 1, 0,  0,  0,  4,  2'd3, CPU_A,  0, 0);
        vecs[16] = mk("ref16", 1, 0,  0,  0,  0,  2'd3, CPU_A,  0, 0);
        vecs[17] = mk("ref17", 1, 0,  0,  0,  0,  2'd3, CPU_A,  0, 0);
        vecs[18] = mk("ref18", 1, 0,  0,  0,  0,  2'd3, CPU_A,  0, 0);
        vecs[19] = mk("ref19", 1, 0,  0,  0,  0,  2'd3, CPU_A,  0, 0);
        vecs[20] = mk("ref20", 1, 0,  0,  0,  0,  2'd3, CPU_A,  0, 0);
        vecs[21] = mk("ref21", 1, 0,  0,  0,  0,  2'd0, CPU_A,  0, 0);
        vecs[22] = mk("en22",  0, 0,  1,  0,  1,  2'd3, CPU_A,  0, 0);
        vecs[23] = mk("en23",  0, 1,  1,  0,  0,  2'd0, CPU_A,  0, 0);
        vecs[24] = mk("en24",  0, 0,  1,  0,  0,  2'd0, CPU_A,  0, 0);
        vecs[25] = mk("en25",  1, 0,  1,  0,  0,  2'd2, CPU_A,  0, 0);
        vecs[26] = mk("en26",  1, 0,  0,  0,  0,  2'd0, CPU_A,  1, 0);
        vecs[27] = mk("en27",  0, 0,  0,  0,  0,  2'd0, CPU_A,  0, 0);
        vecs[28] = mk("en28",  1, 0,  1,  0,  0,  2'd2, CPU_A,  0, 0);
        vecs[29] = mk("en29",  0, 0,  0,  0,  0,  2'd0, CPU_A,  1, 0);
        vecs[30] = mk("g30",   1, 0,  0,  0,  0,  2'd0, CPU_A,  0, 0);

        // Reset with cx parked at 0 so the first cycle after release is phase 0.
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst owner", 64'(owner), 64'd0);
        check("rst vram_addr", 64'(vram_addr), 64'd0);
        check("rst vram_we", 64'(vram_we), 64'd0);
        check("rst vram_refresh", 64'(vram_refresh), 64'd0);
        check("rst vram_wdata", 64'(vram_wdata), 64'd0);
        check("rst acks", 64'({cpu_ack, cmd_ack}), 64'd0);
        check("rst cpu_rdata", 64'(cpu_rdata), 64'd0);

        for (int i = 0; i < 31; i++) run_group(vecs[i], i);

        // CPU write: access held for the whole group, read data left alone.
        enable     = 1'b1;
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 18'h1ABCD;
        cpu_wdata  = 32'h12345678;
        cpu_wmask  = 4'b0011;
        vram_rdata = 32'hDEADBEEF;
        repeat (4) step();
        for (int p = 0; p < 4; p++) begin
            check("wr owner", 64'(owner), 64'd2);
            check("wr vram_we", 64'(vram_we), 64'd1);
            check("wr vram_addr", 64'(vram_addr), 64'h1ABCD);
            check("wr vram_wdata", 64'(vram_wdata), 64'h12345678);
            check("wr vram_wmask", 64'(vram_wmask), 64'h3);
            check("wr vram_refresh", 64'(vram_refresh), 64'd0);
            if (p == 2) begin
                check("wr cpu_ack", 64'(cpu_ack), 64'd1);
                check("wr cpu_rdata kept", 64'(cpu_rdata), 64'(exp_cpu_rdata));
            end
            if (p == 3) cpu_req = 1'b0;
            step();
        end
        check("wr after owner", 64'(owner), 64'd0);
        check("wr after vram_we", 64'(vram_we), 64'd0);

        // Reset during phase 1 of a CPU read: everything clears, no late ack.
        cpu_we   = 1'b0;
        cpu_addr = CPU_A;
        cpu_req  = 1'b1;
        repeat (4) step();
        check("rd owner", 64'(owner), 64'd2);
        step();
        cpu_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid rst owner", 64'(owner), 64'd0);
        check("mid rst vram_addr", 64'(vram_addr), 64'd0);
        check("mid rst vram_wdata", 64'(vram_wdata), 64'd0);
        check("mid rst vram_wmask", 64'(vram_wmask), 64'd0);
        check("mid rst we/refresh", 64'({vram_we, vram_refresh}), 64'd0);
        check("mid rst cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("mid rst cmd_rdata", 64'(cmd_rdata), 64'd0);
        repeat (4) step();
        reset_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            ack_seen = ack_seen | cpu_ack | cmd_ack;
        end
        check("post rst no ack", 64'(ack_seen), 64'd0);
        check("post rst owner", 64'(owner), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
